// File: rtl/aes_pkg.sv
// Shared AES definitions: block size and the key/sync loader state encoding.
package aes_pkg;

    localparam int unsigned AES_BLOCK_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PRESENT = 2'd2,
        DROP    = 2'd3
    } loader_state_e;

endpackage : aes_pkg

// File: rtl/key_sync_loader.sv
// Deserializes one streamed packet into a 128-bit key and 128-bit sync and
// presents them on a one-deep valid/rdy handshake to the key/sync consumer.
module key_sync_loader
    import aes_pkg::*;
#(
    parameter int unsigned IN_WIDTH_IN_BYTES   = 4,
    parameter int unsigned DATA_WIDTH_IN_BYTES = AES_BLOCK_BYTES
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [IN_WIDTH_IN_BYTES*8-1:0]       in_data,
    input  logic                                 in_valid,
    input  logic                                 in_sop,
    input  logic                                 in_eop,
    input  logic [$clog2(IN_WIDTH_IN_BYTES):0]   in_empty,
    output logic                                 in_rdy,
    output logic [DATA_WIDTH_IN_BYTES*8-1:0]     key,
    output logic [DATA_WIDTH_IN_BYTES*8-1:0]     sync,
    output logic                                 out_valid,
    input  logic                                 out_rdy,
    output logic                                 err_pkt
);

    localparam int unsigned IN_W    = IN_WIDTH_IN_BYTES * 8;
    localparam int unsigned DATA_W  = DATA_WIDTH_IN_BYTES * 8;
    localparam int unsigned SHREG_W = 2 * DATA_W;
    localparam int unsigned WORDS   = (2 * DATA_WIDTH_IN_BYTES) / IN_WIDTH_IN_BYTES;
    localparam int unsigned CNT_W   = $clog2(WORDS) + 1;
    localparam int unsigned EMPTY_W = $clog2(IN_WIDTH_IN_BYTES) + 1;

    loader_state_e        state;
    logic [SHREG_W-1:0]   shreg;
    logic [CNT_W-1:0]     cnt;

    logic                 accept_c;
    logic                 last_c;
    logic                 full_eop_c;
    logic [SHREG_W-1:0]   shifted_c;

    // Word handshake and the shift-register view including the incoming word.
    assign accept_c   = in_valid && in_rdy;
    assign shifted_c  = {shreg[SHREG_W-IN_W-1:0], in_data};
    assign last_c     = (cnt + CNT_W'(1)) == CNT_W'(WORDS);
    assign full_eop_c = in_eop && (in_empty == EMPTY_W'(0));

    // Loader FSM: collects WORDS words, presents the pair, flags malformed packets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            key       <= '0;
            sync      <= '0;
            out_valid <= 1'b0;
            in_rdy    <= 1'b1;
            err_pkt   <= 1'b0;
        end else begin
            err_pkt <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        if (!in_sop) begin
                            // Stray word outside a packet.
                            err_pkt <= 1'b1;
                        end else if (in_eop) begin
                            // Single-word packet can never hold a full pair.
                            err_pkt <= 1'b1;
                        end else begin
                            shreg <= shifted_c;
                            cnt   <= CNT_W'(1);
                            state <= COLLECT;
                        end
                    end
                end

                COLLECT: begin
                    if (accept_c) begin
                        if (in_sop) begin
                            // Restart: older words fall off the top as new ones arrive.
                            err_pkt <= 1'b1;
                            shreg   <= shifted_c;
                            cnt     <= CNT_W'(1);
                            if (in_eop) begin
                                state <= IDLE;
                            end
                        end else if (last_c) begin
                            if (full_eop_c) begin
                                key       <= shifted_c[SHREG_W-1:DATA_W];
                                sync      <= shifted_c[DATA_W-1:0];
                                out_valid <= 1'b1;
                                in_rdy    <= 1'b0;
                                state     <= PRESENT;
                            end else if (in_eop) begin
                                err_pkt <= 1'b1;
                                state   <= IDLE;
                            end else begin
                                err_pkt <= 1'b1;
                                state   <= DROP;
                            end
                            cnt <= '0;
                        end else if (in_eop) begin
                            err_pkt <= 1'b1;
                            cnt     <= '0;
                            state   <= IDLE;
                        end else begin
                            shreg <= shifted_c;
                            cnt   <= cnt + CNT_W'(1);
                        end
                    end
                end

                PRESENT: begin
                    if (out_rdy) begin
                        out_valid <= 1'b0;
                        in_rdy    <= 1'b1;
                        state     <= IDLE;
                    end
                end

                DROP: begin
                    // Tail of an over-long packet; already flagged once.
                    if (accept_c && in_eop) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    out_valid <= 1'b0;
                    in_rdy    <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule : key_sync_loader

// File: tb/tb_key_sync_loader.sv
// Directed bench for key_sync_loader at IN_WIDTH_IN_BYTES=4 (8 words per packet).
`timescale 1ns/1ps
module tb_key_sync_loader;

    logic         clk;
    logic         rst_n;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_sop;
    logic         in_eop;
    logic [2:0]   in_empty;
    logic         in_rdy;
    logic [127:0] key;
    logic [127:0] sync;
    logic         out_valid;
    logic         out_rdy;
    logic         err_pkt;

    int n_checks = 0;
    int n_pass   = 0;

    key_sync_loader #(
        .IN_WIDTH_IN_BYTES   (4),
        .DATA_WIDTH_IN_BYTES (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .in_empty  (in_empty),
        .in_rdy    (in_rdy),
        .key       (key),
        .sync      (sync),
        .out_valid (out_valid),
        .out_rdy   (out_rdy),
        .err_pkt   (err_pkt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for every check in the bench.
    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Word i of a packet whose first byte is base: four consecutive bytes, MSB first.
    function automatic logic [31:0] word_of(input logic [7:0] base, input int i);
        logic [7:0] b;
        b = 8'(base + 8'(4 * i));
        return {b, 8'(b + 8'd1), 8'(b + 8'd2), 8'(b + 8'd3)};
    endfunction

    function automatic logic [127:0] bytes16(input logic [7:0] base);
        logic [127:0] v;
        v = '0;
        for (int j = 0; j < 16; j++) begin
            v = {v[119:0], 8'(base + 8'(j))};
        end
        return v;
    endfunction

    // Present one word and hold it until accepted; returns 1 ns after the accepting edge.
    task automatic push(input logic [31:0] d, input logic sop, input logic eop);
        int g;
        g = 0;
        in_data  = d;
        in_sop   = sop;
        in_eop   = eop;
        in_empty = 3'd0;
        in_valid = 1'b1;
        while (!in_rdy && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        if (!in_rdy) check("rdy_timeout", 256'(in_rdy), 256'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    // Full well-formed 8-word packet.
    task automatic send_pkt(input logic [7:0] base);
        for (int i = 0; i < 8; i++) begin
            push(word_of(base, i), i == 0, i == 7);
        end
    endtask

    logic [127:0] k_hold;
    logic [127:0] s_hold;

    initial begin
        rst_n    = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        in_empty = '0;
        out_rdy  = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_key", 256'(key), 256'(0));
        check("rst_sync", 256'(sync), 256'(0));
        check("rst_err", 256'(err_pkt), 256'(0));
        check("rst_in_rdy", 256'(in_rdy), 256'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Good packet, consumer ready.
        send_pkt(8'h00);
        check("t1_valid", 256'(out_valid), 256'(1));
        check("t1_key", 256'(key), 256'(128'h000102030405060708090A0B0C0D0E0F));
        check("t1_sync", 256'(sync), 256'(128'h101112131415161718191A1B1C1D1E1F));
        check("t1_err", 256'(err_pkt), 256'(0));
        check("t1_in_rdy_present", 256'(in_rdy), 256'(0));
        @(posedge clk); #1;
        check("t1_valid_drop", 256'(out_valid), 256'(0));
        check("t1_in_rdy_back", 256'(in_rdy), 256'(1));

        // Backpressure with a second packet pending.
        out_rdy = 1'b0;
        send_pkt(8'h00);
        k_hold   = key;
        s_hold   = sync;
        in_data  = word_of(8'h40, 0);
        in_sop   = 1'b1;
        in_eop   = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("t2_hold_valid", 256'(out_valid), 256'(1));
            check("t2_hold_rdy", 256'(in_rdy), 256'(0));
            check("t2_hold_key", 256'(key), 256'(128'h000102030405060708090A0B0C0D0E0F));
            check("t2_hold_sync", 256'(sync), 256'(s_hold));
            @(posedge clk); #1;
        end
        out_rdy = 1'b1;
        @(posedge clk); #1;
        check("t2_release_valid", 256'(out_valid), 256'(0));
        check("t2_release_rdy", 256'(in_rdy), 256'(1));
        check("t2_key_kept", 256'(key), 256'(k_hold));
        send_pkt(8'h40);
        check("t2_valid", 256'(out_valid), 256'(1));
        check("t2_key", 256'(key), 256'(bytes16(8'h40)));
        check("t2_sync", 256'(sync), 256'(bytes16(8'h50)));
        @(posedge clk); #1;

        // Short packet: eop on word 5.
        for (int i = 0; i < 5; i++) begin
            push(word_of(8'h60, i), i == 0, i == 4);
            check("t3_err", 256'(err_pkt), 256'(i == 4));
            check("t3_no_valid", 256'(out_valid), 256'(0));
        end
        @(posedge clk); #1;
        check("t3_err_single", 256'(err_pkt), 256'(0));
        send_pkt(8'h60);
        check("t3_valid", 256'(out_valid), 256'(1));
        check("t3_key", 256'(key), 256'(bytes16(8'h60)));
        check("t3_sync", 256'(sync), 256'(bytes16(8'h70)));
        @(posedge clk); #1;

        // Long packet: 10 words, eop on word 10.
        for (int i = 0; i < 10; i++) begin
            push(word_of(8'h80, i), i == 0, i == 9);
            check("t4_err", 256'(err_pkt), 256'(i == 7));
            check("t4_no_valid", 256'(out_valid), 256'(0));
        end
        @(posedge clk); #1;
        check("t4_idle_rdy", 256'(in_rdy), 256'(1));
        check("t4_key_unchanged", 256'(key), 256'(bytes16(8'h60)));

        // sop reasserted on word 4.
        for (int i = 0; i < 3; i++) begin
            push(word_of(8'h80, i), i == 0, 1'b0);
            check("t5_err_pre", 256'(err_pkt), 256'(0));
        end
        for (int i = 0; i < 8; i++) begin
            push(word_of(8'hA0, i), i == 0, i == 7);
            check("t5_err", 256'(err_pkt), 256'(i == 0));
        end
        check("t5_valid", 256'(out_valid), 256'(1));
        check("t5_key", 256'(key), 256'(bytes16(8'hA0)));
        check("t5_sync", 256'(sync), 256'(bytes16(8'hB0)));
        @(posedge clk); #1;

        // Reset while presenting.
        out_rdy = 1'b0;
        send_pkt(8'hC0);
        check("t6_valid_pre", 256'(out_valid), 256'(1));
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 256'(out_valid), 256'(0));
        check("t6_rst_key", 256'(key), 256'(0));
        check("t6_rst_sync", 256'(sync), 256'(0));
        @(negedge clk);
        rst_n   = 1'b1;
        out_rdy = 1'b1;
        @(posedge clk); #1;
        check("t6_rdy_after", 256'(in_rdy), 256'(1));
        send_pkt(8'hE0);
        check("t6_valid", 256'(out_valid), 256'(1));
        check("t6_key", 256'(key), 256'(bytes16(8'hE0)));
        check("t6_sync", 256'(sync), 256'(bytes16(8'hF0)));
        @(posedge clk); #1;
        check("t6_valid_drop", 256'(out_valid), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_key_sync_loader
